sum_frame_accumulator: RTL and testbench
========================================

// Module: sum_frame_accumulator
// PURPOSE
//  - Downstream consumer of the 4-bit registered adder stage.
//  - Takes its {Overflow,Sum} result stream, accumulates FRAME_LEN valid samples into a wide total, and counts samples with Overflow set.
//  - Presents the frame result on a valid/ready handshake to the display/readout logic.
// PARAMETERS
//  - ACC_W      12  width of accumulated total (>=5)
//  - CNT_W       8  width of overflow-event counter
//  - FRAME_LEN  16  valid samples per frame (>=1, <2^16)
// PORTS
//  - Clk        in   1      rising-edge clock
//  - Rst        in   1      synchronous, active-high reset
//  - Start      in   1      begin new frame (honoured only in IDLE)
//  - In_valid   in   1      Sum/Overflow valid this cycle
//  - Sum        in   4      adder sum
//  - Overflow   in   1      adder carry-out
//  - Out_ready  in   1      consumer accepts result
//  - Out_valid  out  1      frame result valid
//  - Total      out  ACC_W  accumulated frame total
//  - Ovf_count  out  CNT_W  number of samples with Overflow=1
//  - Wrapped    out  1      sticky: Total exceeded 2^ACC_W-1 this frame
//  - Busy       out  1      high in ACCUM
// BEHAVIOUR
//  - One clock, Clk; Rst synchronous active-high, overrides everything.
//  - Reset values: state=IDLE; Out_valid=0, Busy=0, Total=0, Ovf_count=0, Wrapped=0; sample counter=0.
//  - FSM states IDLE, ACCUM, DONE.
//  - IDLE:
//    - Start=1 -> ACCUM next cycle; Total, Ovf_count, Wrapped and sample counter cleared on same edge.
//    - In_valid ignored.
//  - ACCUM (Busy=1):
//    - Each In_valid cycle adds 5-bit {Overflow,Sum} (0..31), zero-extended to ACC_W+1, into Total.
//    - Ovf_count += Overflow; sample counter +1.
//    - In_valid=0 cycles change nothing; frame length counts valid samples, not cycles.
//    - Sample with counter==FRAME_LEN-1 -> DONE; Out_valid=1 the cycle after the last sample is accepted (latency 1).
//    - Start ignored.
//  - DONE:
//    - Out_valid=1; Total/Ovf_count/Wrapped held stable; In_valid and Start ignored.
//    - Out_valid & Out_ready -> IDLE next cycle. Start in the same cycle is NOT honoured; Start must be re-issued in IDLE.
//    - Total/Ovf_count/Wrapped keep their last values in IDLE until next accepted Start.
//  - Arithmetic:
//    - Default: Total wraps modulo 2^ACC_W.
//    - Wrapped set whenever the ACC_W+1 add carries out; it stays set until the next Start.
//    - Ovf_count always saturates at 2^CNT_W-1; it never wraps.
//  - Rst mid-frame or in DONE: immediate return to IDLE with reset values; the partial result is discarded.
// CONFIGURATION
//  - Macro SUM_FRAME_SATURATE_EN.
//  - Defined: on carry-out, Total clamps to 2^ACC_W-1 and stays there for the rest of the frame. Wrapped is still set.
//  - Undefined: modulo wrap as above.
// STRUCTURE
//  - Shared package holds:
//    - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2
//    - sample width constant SAMPLE_W=5
//  - Sub-module sat_counter (parameterised width, inc, clear, saturate) serves Ovf_count and the sample counter.
//  - FSM and accumulator stay in the top module.
// TESTING
//  - Reset: Rst=1 for 2 cycles with Start/In_valid toggling -> all outputs 0, Busy=0, state IDLE.
//  - Full frame, defaults: Start, then 16 valid samples Sum=4'hF, Overflow=1 -> Out_valid 1 cycle after last sample, Total=496, Ovf_count=16, Wrapped=0.
//  - Gapped input: In_valid every other cycle, Sum=4'd3, Overflow=0 -> DONE after the 16th valid sample (~32 cycles), Total=48, Ovf_count=0.
//  - Backpressure: Out_ready=0 for 5 cycles in DONE while In_valid=1 and Start=1 -> Out_valid/Total stable. Out_ready=1 with Start=1 -> IDLE, no new frame. Start next cycle -> ACCUM.
//  - Width edge, ACC_W=8: 16 samples of 31:
//    - without SUM_FRAME_SATURATE_EN -> Total=240, Wrapped=1
//    - with SUM_FRAME_SATURATE_EN -> Total=255, Wrapped=1
//  - Reset mid-frame: Rst after 7 samples -> IDLE, Total=0. New Start + 16 samples of 1 -> Total=16.

Source files
------------

// File: rtl/sum_frame_accumulator_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and
// datapath widths.
package sum_frame_accumulator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Incoming sample is {Overflow, Sum}, range 0..31
    localparam int unsigned SAMPLE_W = 5;

    // Sample counter width; FRAME_LEN is below 2^16
    localparam int unsigned SCNT_W = 16;

endpackage : sum_frame_accumulator_pkg

// File: rtl/sum_frame_accumulator_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset (count -> 0)
//   clear_i  synchronous clear, wins over inc_i
//   inc_i    increment by one; holds at all-ones instead of wrapping
//   count_o  current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, else increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/sum_frame_accumulator.sv
// Accumulates FRAME_LEN valid {Overflow,Sum} samples from the 4-bit adder
// stage into a wide total, counts samples with Overflow set, and offers the
// frame result on a valid/ready handshake.
// Optional feature: define SUM_FRAME_SATURATE_EN to clamp Total at
// 2^ACC_W-1 on carry-out instead of wrapping modulo 2^ACC_W.
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset
//   Start      begin a new frame (honoured only in IDLE)
//   In_valid   Sum/Overflow valid this cycle
//   Sum        adder sum (4 bits)
//   Overflow   adder carry-out
//   Out_ready  consumer accepts the result
//   Out_valid  frame result valid (DONE)
//   Total      accumulated frame total (ACC_W bits)
//   Ovf_count  saturating count of samples with Overflow=1 (CNT_W bits)
//   Wrapped    sticky: the total carried out of ACC_W bits this frame
//   Busy       high while accumulating
module sum_frame_accumulator
    import sum_frame_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             In_valid,
    input  logic [3:0]       Sum,
    input  logic             Overflow,
    input  logic             Out_ready,
    output logic             Out_valid,
    output logic [ACC_W-1:0] Total,
    output logic [CNT_W-1:0] Ovf_count,
    output logic             Wrapped,
    output logic             Busy
);

    localparam int unsigned EXT_W = ACC_W + 1;

    state_t state_q;
    state_t state_d;

    logic out_valid_q;
    logic out_valid_d;
    logic busy_q;
    logic busy_d;

    logic [ACC_W-1:0]    total_q;
    logic [ACC_W-1:0]    total_d;
    logic                wrapped_q;
    logic                wrapped_d;

    logic [SCNT_W-1:0]   scnt;
    logic [CNT_W-1:0]    ovf_cnt;

    logic                frame_start_c;
    logic                take_c;
    logic                last_c;
    logic [SAMPLE_W-1:0] sample_c;
    logic [EXT_W-1:0]    sum_ext_c;
    logic                carry_c;

    // Handshake-level qualifiers
    assign frame_start_c = (state_q == ST_IDLE) && Start;
    assign take_c        = (state_q == ST_ACCUM) && In_valid;
    assign last_c        = take_c && (scnt == SCNT_W'(FRAME_LEN - 1));

    // State register plus registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; a Start coinciding with the DONE handshake is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start)     state_d = ST_ACCUM;
            ST_ACCUM: if (last_c)    state_d = ST_DONE;
            ST_DONE:  if (Out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered alongside it
    always_comb begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_ACCUM: busy_d      = 1'b1;
            ST_DONE:  out_valid_d = 1'b1;
            default:  ;
        endcase
    end

    // Accumulator: one extra bit exposes the carry-out
    assign sample_c  = {Overflow, Sum};
    assign sum_ext_c = {1'b0, total_q} + EXT_W'(sample_c);
    assign carry_c   = sum_ext_c[ACC_W];

    always_comb begin
        total_d   = total_q;
        wrapped_d = wrapped_q;
        if (frame_start_c) begin
            total_d   = '0;
            wrapped_d = 1'b0;
        end else if (take_c) begin
`ifdef SUM_FRAME_SATURATE_EN
            // Once clamped at all-ones any non-zero sample carries again,
            // so the clamp holds for the rest of the frame
            total_d = carry_c ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
`else
            total_d = sum_ext_c[ACC_W-1:0];
`endif
            wrapped_d = wrapped_q | carry_c;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            total_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            total_q   <= total_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Overflow-event counter, saturating
    sat_counter #(
        .W (CNT_W)
    ) u_ovf_cnt (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .clear_i (frame_start_c),
        .inc_i   (take_c && Overflow),
        .count_o (ovf_cnt)
    );

    // Valid-sample counter within the frame
    sat_counter #(
        .W (SCNT_W)
    ) u_sample_cnt (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .clear_i (frame_start_c),
        .inc_i   (take_c),
        .count_o (scnt)
    );

    assign Out_valid = out_valid_q;
    assign Busy      = busy_q;
    assign Total     = total_q;
    assign Wrapped   = wrapped_q;
    assign Ovf_count = ovf_cnt;

endmodule : sum_frame_accumulator

// File: tb/tb_sum_frame_accumulator.sv
// Scoreboard bench: two instances share stimulus (12-bit total / 8-bit
// counter, and 8-bit total / 3-bit counter) so width edges are exercised.
module tb_sum_frame_accumulator;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       In_valid;
    logic [3:0] Sum;
    logic       Overflow;
    logic       Out_ready;

    logic        ov_a, wr_a, bz_a;
    logic [11:0] tot_a;
    logic [7:0]  oc_a;
    logic        ov_b, wr_b, bz_b;
    logic [7:0]  tot_b;
    logic [2:0]  oc_b;

    localparam int unsigned FLEN = 16;

    typedef struct {
        int unsigned tot_a;
        int unsigned wr_a;
        int unsigned oc_a;
        int unsigned tot_b;
        int unsigned wr_b;
        int unsigned oc_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    sum_frame_accumulator #(.ACC_W(12), .CNT_W(8), .FRAME_LEN(FLEN)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_valid(In_valid), .Sum(Sum),
        .Overflow(Overflow), .Out_ready(Out_ready), .Out_valid(ov_a),
        .Total(tot_a), .Ovf_count(oc_a), .Wrapped(wr_a), .Busy(bz_a)
    );

    sum_frame_accumulator #(.ACC_W(8), .CNT_W(3), .FRAME_LEN(FLEN)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_valid(In_valid), .Sum(Sum),
        .Overflow(Overflow), .Out_ready(Out_ready), .Out_valid(ov_b),
        .Total(tot_b), .Ovf_count(oc_b), .Wrapped(wr_b), .Busy(bz_b)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: frame result from the arithmetic sum of its samples
    function automatic int unsigned ref_total(int unsigned s, int unsigned w);
        int unsigned lim;
        lim = (32'd1 << w) - 1;
`ifdef SUM_FRAME_SATURATE_EN
        return (s > lim) ? lim : s;
`else
        return s % (lim + 1);
`endif
    endfunction

    function automatic int unsigned ref_wrap(int unsigned s, int unsigned w);
        return (s > ((32'd1 << w) - 1)) ? 1 : 0;
    endfunction

    function automatic int unsigned ref_cnt(int unsigned n, int unsigned w);
        int unsigned lim;
        lim = (32'd1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    function automatic exp_t model(int unsigned s, int unsigned n);
        exp_t e;
        e.tot_a = ref_total(s, 12);
        e.wr_a  = ref_wrap(s, 12);
        e.oc_a  = ref_cnt(n, 8);
        e.tot_b = ref_total(s, 8);
        e.wr_b  = ref_wrap(s, 8);
        e.oc_b  = ref_cnt(n, 3);
        return e;
    endfunction

    // Monitor: every cycle a result is presented it must match the head of
    // the queue (also proves stability under backpressure); pop on accept
    always @(negedge Clk) begin
        if (!Rst && (ov_a || ov_b)) begin
            chk("valid_pair", 32'(ov_b), 32'(ov_a));
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("total_a",   32'(tot_a), exp_q[0].tot_a);
                chk("wrapped_a", 32'(wr_a),  exp_q[0].wr_a);
                chk("ovfcnt_a",  32'(oc_a),  exp_q[0].oc_a);
                chk("total_b",   32'(tot_b), exp_q[0].tot_b);
                chk("wrapped_b", 32'(wr_b),  exp_q[0].wr_b);
                chk("ovfcnt_b",  32'(oc_b),  exp_q[0].oc_b);
                if (Out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Inputs change just after the rising edge; they are captured on the next one
    task automatic drive(input logic rs, input logic st, input logic iv,
                         input logic [3:0] sm, input logic of, input logic rdy);
        @(posedge Clk);
        #1;
        Rst = rs; Start = st; In_valid = iv; Sum = sm; Overflow = of; Out_ready = rdy;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_total_a"}, 32'(tot_a), 0);
        chk({tag, "_ovf_a"},   32'(oc_a),  0);
        chk({tag, "_wrap_a"},  32'(wr_a),  0);
        chk({tag, "_busy_a"},  32'(bz_a),  0);
        chk({tag, "_valid_a"}, 32'(ov_a),  0);
        chk({tag, "_total_b"}, 32'(tot_b), 0);
        chk({tag, "_busy_b"},  32'(bz_b),  0);
    endtask

    // mode 0: 31 every cycle; 1: 3 every other cycle; 2: random; 3: 1 every cycle
    task automatic run_frame(input int mode);
        int unsigned acc = 0;
        int unsigned nov = 0;
        int unsigned n   = 0;
        int          cyc = 0;
        logic        iv, of;
        logic [3:0]  sm;
        int          bp;
        drive(0, 1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        while (n < FLEN && cyc < 400) begin
            case (mode)
                0:       begin iv = 1'b1;           sm = 4'hF;          of = 1'b1; end
                1:       begin iv = 1'(cyc % 2);    sm = 4'd3;          of = 1'b0; end
                3:       begin iv = 1'b1;           sm = 4'd1;          of = 1'b0; end
                default: begin iv = ($urandom_range(0, 9) < 7); sm = 4'($urandom); of = 1'($urandom); end
            endcase
            drive(0, 1'($urandom), iv, sm, of, 1'($urandom));
            if (cyc == 0) chk("busy_after_start", 32'(bz_a), 1);
            if (iv) begin
                acc += 32'({of, sm});
                nov += 32'(of);
                n++;
            end
            cyc++;
        end
        if (n < FLEN) chk("frame_cycle_budget", n, FLEN);
        exp_q.push_back(model(acc, nov));
        bp = (mode == 1) ? 5 : $urandom_range(0, 4);
        drive(0, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        chk("valid_latency", 32'(ov_a), 1);
        chk("busy_in_done",  32'(bz_a), 0);
        repeat (bp) drive(0, 1'b1, 1'b1, 4'($urandom), 1'($urandom), 1'b0);
        drive(0, 1'b1, 1'b1, 4'($urandom), 1'($urandom), 1'b1);
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("accept_valid_low", 32'(ov_a), 0);
        chk("accept_no_restart", 32'(bz_a), 0);
        drive(0, 1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        chk("idle_stays", 32'(bz_a), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1; Start = 1'b0; In_valid = 1'b0; Sum = 4'd0; Overflow = 1'b0; Out_ready = 1'b0;
        // Reset with noisy control inputs
        drive(1, 1, 1, 4'hF, 1, 1);
        drive(1, 0, 1, 4'hA, 0, 0);
        drive(0, 0, 0, 4'd0, 0, 0);
        check_idle_zero("reset");

        run_frame(0);
        run_frame(1);

        // Reset after 7 samples discards the partial frame
        drive(0, 1, 0, 4'd0, 0, 0);
        repeat (7) drive(0, 0, 1, 4'($urandom_range(1, 15)), 1'b1, 0);
        drive(1, 1, 1, 4'hF, 1, 0);
        drive(0, 0, 0, 4'd0, 0, 0);
        check_idle_zero("midreset");
        run_frame(3);

        repeat (6) run_frame(2);

        repeat (3) drive(0, 0, 0, 4'd0, 0, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sum_frame_accumulator
